exe_alu_md: RTL

- Next-generation execute-stage ALU for the pipelined MIPS core.
- Merges operand forwarding selection, a full-width integer ALU, and an iterative multiply/divide unit with HI/LO registers into one parametrised block.
- Single-cycle ops produce a registered result one cycle after issue.
- MULTU/DIVU run for WIDTH cycles. During that time the block asserts a stall to hold the ID/EX stage.

---
 rtl/exe_alu_md.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/exe_alu_md.sv
// Execute-stage ALU with operand forwarding muxes and an iterative MULTU/DIVU unit owning HI/LO.
// state | meaning:  IDLE single-cycle ops accepted | MUL shift-add step | DIV restoring-divide step
module exe_alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] rf_a,
  input  logic [WIDTH-1:0] rf_b,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] fwd_exe,
  input  logic [WIDTH-1:0] fwd_mem,
  input  logic [1:0]       a_sel,
  input  logic [1:0]       b_sel,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [SHW:0] CNT_INIT = WIDTH[SHW:0];
  localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

  state_t             state;
  logic [SHW:0]       cnt;
  logic [2*WIDTH-1:0] md_x;
  logic [WIDTH-1:0]   md_d;
  logic [2*WIDTH-1:0] md_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;

  logic [WIDTH-1:0] op_a, op_b, add_s, sub_s, res_n;
  logic             ovf_n, accept, is_md;
  logic [SHW-1:0]   sh;

  always_comb begin
    case (a_sel)
      2'd0:    op_a = rf_a;
      2'd1:    op_a = fwd_exe;
      2'd2:    op_a = fwd_mem;
      default: op_a = '0;
    endcase
    case (b_sel)
      2'd0:    op_b = rf_b;
      2'd1:    op_b = imm;
      2'd2:    op_b = fwd_exe;
      default: op_b = fwd_mem;
    endcase
  end

  assign add_s  = op_a + op_b;
  assign sub_s  = op_a - op_b;
  assign sh     = op_b[SHW-1:0];
  assign busy   = (state != IDLE);
  assign accept = in_valid & ~busy & ~flush;
  assign is_md  = (alu_op[3:1] == 3'b110);

  always_comb begin
    res_n = '0;
    ovf_n = 1'b0;
    case (alu_op)
      4'b0000: begin
        res_n = add_s;
        ovf_n = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_s[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'b0100: begin
        res_n = sub_s;
        ovf_n = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_s[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'b0101: res_n = op_a | op_b;
      4'b0001: res_n = op_a & op_b;
      4'b0010: res_n = op_a ^ op_b;
      4'b0011: res_n = ~(op_a | op_b);
      4'b0110: res_n = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0111: res_n = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      4'b1000: res_n = op_a << sh;
      4'b1001: res_n = op_a >> sh;
      4'b1010: res_n = $unsigned($signed(op_a) >>> sh);
      4'b1110: res_n = hi;
      4'b1111: res_n = lo;
      default: res_n = '0;
    endcase
  end

  // md_x holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV,
  // so the final value maps straight onto {hi, lo} for both ops.
  assign mul_sum   = {1'b0, md_x[2*WIDTH-1:WIDTH]} + (md_x[0] ? {1'b0, md_d} : {(WIDTH+1){1'b0}});
  assign div_trial = {md_x[2*WIDTH-1:WIDTH], md_x[WIDTH-1]} - {1'b0, md_d};

  always_comb begin
    md_next = md_x;
    if (state == DIV) begin
      if (!div_trial[WIDTH])
        md_next = {div_trial[WIDTH-1:0], md_x[WIDTH-2:0], 1'b1};
      else
        md_next = {md_x[2*WIDTH-2:0], 1'b0};
    end else begin
      md_next = {mul_sum, md_x[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      md_x      <= '0;
      md_d      <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      md_done   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      md_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_md) begin
              state <= alu_op[0] ? DIV : MUL;
              cnt   <= CNT_INIT;
              md_d  <= alu_op[0] ? op_b : op_a;
              md_x  <= {{WIDTH{1'b0}}, (alu_op[0] ? op_a : op_b)};
            end else begin
              result    <= res_n;
              zero      <= (res_n == '0);
              ovf       <= ovf_n;
              out_valid <= 1'b1;
            end
          end
        end
        default: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            md_x <= md_next;
            if (cnt == CNT_ONE) begin
              hi      <= md_next[2*WIDTH-1:WIDTH];
              lo      <= md_next[WIDTH-1:0];
              md_done <= 1'b1;
              state   <= IDLE;
              cnt     <= '0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
      endcase
    end
  end

endmodule
